alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode encodings and widths for the two-requester ALU arbiter.
// Single source of the ALU opcode set used by the arbiter, its bench and the external ALU.
package alu_arbiter_pkg;

   localparam int unsigned XLEN_DEF = 64;
   localparam int unsigned ALUOP_W  = 4;
   localparam int unsigned NUM_REQ  = 2;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [ALUOP_W-1:0] ALU_XOR = 4'b0100;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0110;
   localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0111;

   // One-hot two-way grant to requester index (bit 1 set means requester 1).
   function automatic logic gnt_to_idx(input logic [NUM_REQ-1:0] gnt);
      return gnt[1];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: valid pair, priority pointer and enable in, one-hot grant out.
module rr_arb2
   import alu_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic               ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt_c
);

   // A lone requester always wins; contention is settled by ptr or fixed to req0.
   always_comb begin
      gnt_c = '0;
      if (en) begin
         case (valid)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (RR_EN && ptr) ? 2'b10 : 2'b01;
            default: gnt_c = '0;
         endcase
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters and registers
// the result with the owning requester id.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter bit          RR_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [3:0]         req0_aluop,
   input  logic [XLEN-1:0]    req0_op1,
   input  logic [XLEN-1:0]    req0_op2,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [3:0]         req1_aluop,
   input  logic [XLEN-1:0]    req1_op1,
   input  logic [XLEN-1:0]    req1_op2,
   output logic [3:0]         alu_aluop,
   output logic [XLEN-1:0]    alu_op1,
   output logic [XLEN-1:0]    alu_op2,
   input  logic [XLEN-1:0]    alu_result,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [XLEN-1:0]    rsp_result
);

   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_id_q, rsp_id_d;
   logic [XLEN-1:0]    rsp_result_q, rsp_result_d;
   logic               ptr_q, ptr_d;
   logic               can_accept_c;
   logic [NUM_REQ-1:0] gnt_c;
   logic               gnt_any_c;
   logic               gnt_idx_c;

   // A new op may only enter when the response slot is free or draining this cycle.
   assign can_accept_c = (!rsp_valid_q || rsp_ready) && !rst;

   rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .valid (NUM_REQ'({req1_valid, req0_valid})),
      .ptr   (ptr_q),
      .en    (can_accept_c),
      .gnt_c (gnt_c)
   );

   assign gnt_any_c  = |gnt_c;
   assign gnt_idx_c  = gnt_to_idx(gnt_c);
   assign req0_ready = gnt_c[0];
   assign req1_ready = gnt_c[1];

   // ALU drive follows the grant; idle cycles present all-zero operands.
   always_comb begin
      alu_aluop = '0;
      alu_op1   = '0;
      alu_op2   = '0;
      if (gnt_c[0]) begin
         alu_aluop = req0_aluop;
         alu_op1   = req0_op1;
         alu_op2   = req0_op2;
      end else if (gnt_c[1]) begin
         alu_aluop = req1_aluop;
         alu_op1   = req1_op1;
         alu_op2   = req1_op2;
      end
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      ptr_d        = ptr_q;
      if (gnt_any_c) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = gnt_idx_c;
         rsp_result_d = alu_result;
         ptr_d        = ~gnt_idx_c;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         ptr_q        <= 1'b0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         ptr_q        <= ptr_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances, external ALU model,
// response scoreboard plus per-scenario grant checks.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int unsigned XLEN = 64;

   typedef struct {
      logic            id;
      logic [XLEN-1:0] res;
   } exp_t;

   logic clk = 1'b0;
   logic rst, v0, v1, rsp_ready;
   logic [3:0] op0, op1;
   logic [XLEN-1:0] a0, b0, a1, b1;

   logic r0_rdy, r1_rdy, rsp_valid, rsp_id;
   logic [3:0] alu_aluop;
   logic [XLEN-1:0] alu_op1, alu_op2, alu_result, rsp_result;

   logic f0_rdy, f1_rdy, f_valid, f_id;
   logic [3:0] f_aluop;
   logic [XLEN-1:0] f_op1, f_op2, f_result, f_rsp_result;

   int errors = 0;
   int checks = 0;
   exp_t exp_q[$];
   logic m_valid = 1'b0;
   logic m_ptr = 1'b0;
   logic [3:0] op_tab [5] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND};

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_XOR: return a ^ b;
         ALU_OR:  return a | b;
         ALU_AND: return a & b;
         default: return '0;
      endcase
   endfunction

   // Expected one-hot grant for the round-robin instance from bench-side state.
   function automatic logic [1:0] model_gnt(input logic r, input logic a, input logic b,
                                            input logic rr, input logic mv, input logic mp);
      if (r || (mv && !rr)) return 2'b00;
      if (a && b) return mp ? 2'b10 : 2'b01;
      if (a) return 2'b01;
      if (b) return 2'b10;
      return 2'b00;
   endfunction

   assign alu_result = alu_f(alu_aluop, alu_op1, alu_op2);
   assign f_result   = alu_f(f_aluop, f_op1, f_op2);

   alu_arbiter #(.XLEN(XLEN), .RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(r0_rdy), .req0_aluop(op0), .req0_op1(a0), .req0_op2(b0),
      .req1_valid(v1), .req1_ready(r1_rdy), .req1_aluop(op1), .req1_op1(a1), .req1_op2(b1),
      .alu_aluop(alu_aluop), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
   );

   alu_arbiter #(.XLEN(XLEN), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(f0_rdy), .req0_aluop(op0), .req0_op1(a0), .req0_op2(b0),
      .req1_valid(v1), .req1_ready(f1_rdy), .req1_aluop(op1), .req1_op1(a1), .req1_op2(b1),
      .alu_aluop(f_aluop), .alu_op1(f_op1), .alu_op2(f_op2), .alu_result(f_result),
      .rsp_valid(f_valid), .rsp_ready(rsp_ready), .rsp_id(f_id), .rsp_result(f_rsp_result)
   );

   // Scoreboard: push expected response on each modelled grant, compare what the DUT presents.
   always @(posedge clk) begin
      logic cons;
      logic [1:0] g;
      exp_t e;
      cons = m_valid && rsp_ready;
      g = model_gnt(rst, v0, v1, rsp_ready, m_valid, m_ptr);
      if (rst) begin
         exp_q.delete();
         m_valid = 1'b0;
         m_ptr = 1'b0;
      end else begin
         if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
         if (g != 2'b00) begin
            e.id  = g[1];
            e.res = g[1] ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0);
            exp_q.push_back(e);
            m_ptr = ~g[1];
         end
         m_valid = (g != 2'b00) || (m_valid && !rsp_ready);
      end
      #1;
      checks++;
      if (rsp_valid !== m_valid) begin errors++; $display("FAIL sb_valid: got %b want %b", rsp_valid, m_valid); end
      if (m_valid) begin
         checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL sb_empty: response expected but scoreboard empty"); end
         else if (rsp_id !== exp_q[0].id || rsp_result !== exp_q[0].res) begin
            errors++;
            $display("FAIL sb_rsp: got id=%b res=%h want id=%b res=%h", rsp_id, rsp_result, exp_q[0].id, exp_q[0].res);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; rsp_ready = 1'b1;
      v0 = 1'b1; op0 = ALU_AND; a0 = 64'h7; b0 = 64'h9;
      v1 = 1'b1; op1 = ALU_OR;  a1 = 64'h1; b1 = 64'h2;
      #1;
      checks++; if (r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", r1_rdy, r0_rdy); end
      checks++; if (alu_aluop !== 4'd0 || alu_op1 !== '0 || alu_op2 !== '0) begin errors++; $display("FAIL reset_alu: got op=%h a=%h b=%h want 0", alu_aluop, alu_op1, alu_op2); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== '0) begin errors++; $display("FAIL reset_rsp: got v=%b id=%b res=%h want 0", rsp_valid, rsp_id, rsp_result); end
      rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      v0 = 1'b1; op0 = ALU_ADD; a0 = 64'd5; b0 = 64'd3; rsp_ready = 1'b1;
      #1;
      checks++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin errors++; $display("FAIL single_grant: got %b%b want 01", r1_rdy, r0_rdy); end
      checks++; if (alu_aluop !== ALU_ADD || alu_op1 !== 64'd5 || alu_op2 !== 64'd3) begin errors++; $display("FAIL single_alu: got op=%h a=%h b=%h want 0/5/3", alu_aluop, alu_op1, alu_op2); end
      @(negedge clk); v0 = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 64'd8) begin errors++; $display("FAIL single_rsp: got v=%b id=%b res=%h want 1/0/8", rsp_valid, rsp_id, rsp_result); end
   endtask

   task automatic test_both();
      do_reset();
      v0 = 1'b1; op0 = ALU_SUB; a0 = 64'd10;   b0 = 64'd4;
      v1 = 1'b1; op1 = ALU_AND; a1 = 64'hF0;   b1 = 64'h3C; rsp_ready = 1'b1;
      #1;
      checks++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin errors++; $display("FAIL both_first: got %b%b want 01", r1_rdy, r0_rdy); end
      @(negedge clk); v0 = 1'b0; #1;
      checks++; if (rsp_id !== 1'b0 || rsp_result !== 64'd6) begin errors++; $display("FAIL both_rsp0: got id=%b res=%h want 0/6", rsp_id, rsp_result); end
      checks++; if (r1_rdy !== 1'b1 || alu_aluop !== ALU_AND) begin errors++; $display("FAIL both_second: got rdy=%b op=%h want 1/7", r1_rdy, alu_aluop); end
      @(negedge clk); v1 = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 64'h30) begin errors++; $display("FAIL both_rsp1: got v=%b id=%b res=%h want 1/1/30", rsp_valid, rsp_id, rsp_result); end
   endtask

   task automatic test_rr_alternate();
      do_reset();
      v0 = 1'b1; op0 = ALU_XOR; a0 = 64'hFF00; b0 = 64'h0FF0;
      v1 = 1'b1; op1 = ALU_OR;  a1 = 64'h1;    b1 = 64'h2; rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2)) begin errors++; $display("FAIL rr_seq[%0d]: got v=%b id=%b want 1/%0d", i, rsp_valid, rsp_id, i % 2); end
         checks++; if (f_valid !== 1'b1 || f_id !== 1'b0 || f_rsp_result !== 64'hF0F0) begin errors++; $display("FAIL fp_seq[%0d]: got v=%b id=%b res=%h want 1/0/f0f0", i, f_valid, f_id, f_rsp_result); end
      end
      v0 = 1'b0; v1 = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      v0 = 1'b1; op0 = ALU_ADD; a0 = 64'd1; b0 = 64'd2; rsp_ready = 1'b1;
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b1; op1 = ALU_SUB; a1 = 64'd9; b1 = 64'd4; rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (r1_rdy !== 1'b0 || r0_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b%b want 00", k, r1_rdy, r0_rdy); end
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 64'd3) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%b res=%h want 1/0/3", k, rsp_valid, rsp_id, rsp_result); end
         @(negedge clk);
      end
      rsp_ready = 1'b1; #1;
      checks++; if (r1_rdy !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", r1_rdy); end
      @(negedge clk); v1 = 1'b0; #1;
      checks++; if (rsp_id !== 1'b1 || rsp_result !== 64'd5) begin errors++; $display("FAIL bp_rsp: got id=%b res=%h want 1/5", rsp_id, rsp_result); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      v0 = 1'b1; op0 = ALU_AND; a0 = 64'hAA; b0 = 64'h0F; rsp_ready = 1'b0;
      @(negedge clk); v0 = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %b want 0", rsp_valid); end
      v0 = 1'b1; op0 = ALU_ADD; a0 = 64'd100; b0 = 64'd23;
      v1 = 1'b1; op1 = ALU_XOR; a1 = 64'd6;   b1 = 64'd3; rsp_ready = 1'b1;
      #1;
      checks++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin errors++; $display("FAIL midrst_first: got %b%b want 01", r1_rdy, r0_rdy); end
      @(negedge clk); v0 = 1'b0; #1;
      checks++; if (rsp_id !== 1'b0 || rsp_result !== 64'd123) begin errors++; $display("FAIL midrst_rsp0: got id=%b res=%h want 0/7b", rsp_id, rsp_result); end
      @(negedge clk); v1 = 1'b0; #1;
      checks++; if (rsp_id !== 1'b1 || rsp_result !== 64'd5) begin errors++; $display("FAIL midrst_rsp1: got id=%b res=%h want 1/5", rsp_id, rsp_result); end
   endtask

   task automatic test_idle();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL idle_last: got %b want 1", rsp_valid); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         checks++; if (alu_aluop !== 4'd0 || alu_op1 !== '0 || alu_op2 !== '0) begin errors++; $display("FAIL idle_alu[%0d]: got op=%h a=%h b=%h want 0", k, alu_aluop, alu_op1, alu_op2); end
         checks++; if (rsp_valid !== 1'b0 || r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin errors++; $display("FAIL idle_rsp[%0d]: got v=%b rdy=%b%b want 0/00", k, rsp_valid, r1_rdy, r0_rdy); end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] g;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         v0 = ($urandom_range(0, 3) != 0); v1 = ($urandom_range(0, 3) != 0);
         op0 = op_tab[$urandom_range(0, 4)]; op1 = op_tab[$urandom_range(0, 4)];
         a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
         a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = model_gnt(rst, v0, v1, rsp_ready, m_valid, m_ptr);
         checks++; if ({r1_rdy, r0_rdy} !== g) begin errors++; $display("FAIL b2b_grant[%0d]: got %b%b want %b", n, r1_rdy, r0_rdy, g); end
      end
      @(negedge clk); v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
      op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      test_reset();
      test_single();
      test_both();
      test_rr_alternate();
      test_backpressure();
      test_reset_mid();
      test_idle();
      test_back_to_back();
      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
